// File: rtl/uart_tx_bus.sv
// Bus-mapped UART transmitter: 8-entry byte FIFO, 8N1 serialiser and a queue-drained interrupt.
// Defining UART_TX_PARITY_EN inserts an even-parity bit and sets status bit 3.
module uart_tx_bus #(
    parameter logic [7:0]  BASE_ADDR    = 8'hE0,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    output logic       UART_TX
);

    localparam int unsigned DEPTH     = 2 ** FIFO_AW;
    localparam int unsigned PW        = FIFO_AW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  STAT_ADDR = 8'(BASE_ADDR + 8'd1);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_CAP = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam logic PARITY_CAP = 1'b0;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_next;
    logic [15:0]   baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_q, tx_next;
    logic          irq_q, irq_set;
    logic          ovf;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    stat_q;
    logic          drive_q;
`ifdef UART_TX_PARITY_EN
    logic          par, par_next;
`endif

    logic       empty, full, pop, push, wr_req, rd_req, ovf_set, baud_done;
    logic [7:0] head;

    // FIFO flags: extra pointer MSB distinguishes full from empty.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head      = mem[rd_ptr[FIFO_AW-1:0]];
    assign wr_req    = BUS_WE && (BUS_ADDR == BASE_ADDR);
    assign rd_req    = !BUS_WE && (BUS_ADDR == STAT_ADDR);
    assign push      = wr_req && (!full || pop);
    assign ovf_set   = wr_req && full && !pop;
    assign baud_done = (baud_cnt == BAUD_LAST);

    // Next-state and serial output; a pop always lands directly in START.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        irq_set    = 1'b0;
        tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    baud_next  = 16'd0;
                    bit_next   = 3'd0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    par_next   = ^head;
`endif
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = 16'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = 16'd0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        shift_next = shift >> 1;
                        bit_next   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_next  = 16'd0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next = 16'd0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        bit_next   = 3'd0;
                        state_next = START;
`ifdef UART_TX_PARITY_EN
                        par_next   = ^head;
`endif
                    end else begin
                        irq_set    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = par_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b0;
            ovf      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            stat_q   <= 8'd0;
            drive_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx_q     <= tx_next;
`ifdef UART_TX_PARITY_EN
            par      <= par_next;
`endif
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            // A drop on the same edge as a status read keeps the flag set.
            if (ovf_set)     ovf <= 1'b1;
            else if (rd_req) ovf <= 1'b0;
            if (irq_set)                irq_q <= 1'b1;
            else if (BUS_INTERRUPT_ACK) irq_q <= 1'b0;
            drive_q <= rd_req;
            if (rd_req) stat_q <= {4'b0, PARITY_CAP, ovf, full, empty};
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= BUS_DATA;
    end

    assign BUS_DATA            = drive_q ? stat_q : 8'hzz;
    assign UART_TX             = tx_q;
    assign BUS_INTERRUPT_RAISE = irq_q;

endmodule

// File: tb/tb_uart_tx_bus.sv
// Self-checking bench for uart_tx_bus: frame table, hand-written corner sequences and
// randomized bus traffic compared every cycle against a queue/frame-timer reference model.
module tb_uart_tx_bus;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
    localparam logic [7:0]  CAP   = 8'h08;
`else
    localparam int unsigned NBITS = 10;
    localparam logic [7:0]  CAP   = 8'h00;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst, we, ack, tb_drive, park;
    logic [7:0] addr, tb_data;
    wire  [7:0] bus_data;
    logic       irq, tx;

    assign bus_data = tb_drive ? tb_data : 8'hzz;

    uart_tx_bus #(.BASE_ADDR(8'hE0), .CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
        .CLK                 (clk),
        .RESET               (rst),
        .BUS_DATA            (bus_data),
        .BUS_ADDR            (addr),
        .BUS_WE              (we),
        .BUS_INTERRUPT_RAISE (irq),
        .BUS_INTERRUPT_ACK   (ack),
        .UART_TX             (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus a frame timer counting cycles into the current frame.
    logic [7:0] mq[$];
    logic       m_ovf, m_irq, m_busy, m_rd;
    int         m_t;
    logic [7:0] m_cur, m_stat;

    function automatic logic model_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / int'(CPB);
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        if (k == 9 && NBITS == 11) return ^m_cur;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0; m_irq = 1'b0; m_busy = 1'b0; m_rd = 1'b0;
        m_t = 0; m_cur = 8'd0; m_stat = 8'd0;
    endfunction

    function automatic void model_edge(logic w, logic [7:0] a, logic [7:0] d, logic k);
        int   pre;
        logic popped, set_irq, ovf_now;
        pre     = mq.size();
        m_stat  = CAP | {5'b0, m_ovf, (pre == DEPTH), (pre == 0)};
        m_rd    = !w && (a == 8'hE1);
        popped  = 1'b0;
        set_irq = 1'b0;
        ovf_now = 1'b0;
        if (m_busy) begin
            if (m_t == int'(FRAME) - 1) begin
                m_busy = 1'b0;
                if (pre != 0) begin
                    m_cur = mq.pop_front(); m_busy = 1'b1; m_t = 0; popped = 1'b1;
                end else begin
                    set_irq = 1'b1;
                end
            end else begin
                m_t++;
            end
        end else if (pre != 0) begin
            m_cur = mq.pop_front(); m_busy = 1'b1; m_t = 0; popped = 1'b1;
        end
        if (w && a == 8'hE0) begin
            if (pre < DEPTH || popped) mq.push_back(d);
            else ovf_now = 1'b1;
        end
        if (ovf_now)   m_ovf = 1'b1;
        else if (m_rd) m_ovf = 1'b0;
        if (set_irq)   m_irq = 1'b1;
        else if (k)    m_irq = 1'b0;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at the falling edge, model the rising edge, sample at the next falling edge.
    task automatic cycle(input logic w, input logic [7:0] a, input logic [7:0] d, input logic k);
        we = w; addr = a; tb_data = d; ack = k; tb_drive = w | park;
        model_edge(w, a, d, k);
        @(posedge clk);
        @(negedge clk);
        check("model_tx", {7'b0, tx}, {7'b0, model_tx()});
        check("model_irq", {7'b0, irq}, {7'b0, m_irq});
        if (m_rd) check("model_status", bus_data, m_stat);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0; addr = 8'h00; ack = 1'b0; tb_drive = 1'b0; park = 1'b0; tb_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] order;   // serial data bits, MSB is the first bit on the wire
        logic       par;
    } frame_vec_t;

    frame_vec_t vecs[7];

    initial begin
        logic exp_bit;
        logic last_rd;
        int   r, wr_pct;
        logic w, k;
        logic [7:0] a;

        vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
        vecs[1] = '{8'h00, 8'b00000000, 1'b0};
        vecs[2] = '{8'hFF, 8'b11111111, 1'b0};
        vecs[3] = '{8'h3C, 8'b00111100, 1'b0};
        vecs[4] = '{8'h07, 8'b11100000, 1'b1};
        vecs[5] = '{8'h03, 8'b11000000, 1'b0};
        vecs[6] = '{8'h55, 8'b10101010, 1'b0};

        do_reset();
        check("reset_tx", {7'b0, tx}, 8'h01);
        check("reset_irq", {7'b0, irq}, 8'h00);

        // Idle with the bench parking a value on the bus: DUT must not be driving.
        park = 1'b1;
        repeat (100) cycle(1'b0, 8'h00, 8'hA0, 1'b0);
        check("idle_bus_released", bus_data, 8'hA0);
        check("idle_tx", {7'b0, tx}, 8'h01);
        park = 1'b0;
        cycle(1'b0, 8'hE1, 8'h00, 1'b0);
        check("reset_status", bus_data, 8'h01 | CAP);
        park = 1'b1;
        cycle(1'b0, 8'h00, 8'hA0, 1'b0);
        check("bus_released_after_read", bus_data, 8'hA0);
        park = 1'b0;

        // Single frames from the table, with mid-bit samples and interrupt timing.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 8'hE0, vecs[i].data, 1'b0);
            check("tx_high_on_write_edge", {7'b0, tx}, 8'h01);
            idle(1);
            check("start_bit_fall", {7'b0, tx}, 8'h00);
            idle(CPB / 2);
            for (int b = 0; b < int'(NBITS); b++) begin
                if (b == 0)                     exp_bit = 1'b0;
                else if (b <= 8)                exp_bit = vecs[i].order[8-b];
                else if (b == 9 && NBITS == 11) exp_bit = vecs[i].par;
                else                            exp_bit = 1'b1;
                check("frame_bit", {7'b0, tx}, {7'b0, exp_bit});
                if (b < int'(NBITS) - 1) idle(CPB);
            end
            idle(CPB / 2 - 1);
            check("irq_before_frame_end", {7'b0, irq}, 8'h00);
            // Odd entries ack on the raising edge: raise must win.
            cycle(1'b0, 8'h00, 8'h00, i[0]);
            check("irq_at_frame_end", {7'b0, irq}, 8'h01);
            cycle(1'b0, 8'h00, 8'h00, 1'b1);
            check("irq_ack_clears", {7'b0, irq}, 8'h00);
        end

        // Three back-to-back writes: contiguous frames, one interrupt.
        cycle(1'b1, 8'hE0, 8'h00, 1'b0);
        cycle(1'b1, 8'hE0, 8'hFF, 1'b0);
        cycle(1'b1, 8'hE0, 8'h3C, 1'b0);
        idle(FRAME - 1);
        check("b2b_start2_no_gap", {7'b0, tx}, 8'h00);
        idle(FRAME);
        check("b2b_start3_no_gap", {7'b0, tx}, 8'h00);
        idle(FRAME - 1);
        check("b2b_no_early_irq", {7'b0, irq}, 8'h00);
        idle(1);
        check("b2b_irq", {7'b0, irq}, 8'h01);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        check("b2b_irq_ack", {7'b0, irq}, 8'h00);

        // Ten consecutive writes: one in flight, eight queued, one dropped.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'hE0, 8'($urandom), 1'b0);
        cycle(1'b0, 8'hE1, 8'h00, 1'b0);
        check("overflow_status", bus_data, 8'h06 | CAP);
        idle(1);
        cycle(1'b0, 8'hE1, 8'h00, 1'b0);
        check("overflow_cleared_status", bus_data, 8'h02 | CAP);
        idle(9 * FRAME);
        check("drain_irq", {7'b0, irq}, 8'h01);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        check("drain_irq_ack", {7'b0, irq}, 8'h00);

        // Reset in the middle of data bit 4 of 8'h55.
        cycle(1'b1, 8'hE0, 8'h55, 1'b0);
        idle(1 + 5 * CPB + CPB / 2);
        check("mid_data_bit4", {7'b0, tx}, 8'h01);
        idle(CPB);
        check("mid_data_bit5", {7'b0, tx}, 8'h00);
        do_reset();
        check("abort_tx_high", {7'b0, tx}, 8'h01);
        check("abort_irq_low", {7'b0, irq}, 8'h00);
        cycle(1'b0, 8'hE1, 8'h00, 1'b0);
        check("abort_status_empty", bus_data, 8'h01 | CAP);
        idle(2 * FRAME);
        check("abort_no_more_frames", {7'b0, tx}, 8'h01);
        check("abort_no_irq", {7'b0, irq}, 8'h00);

        // Randomized traffic; no write directly after a read so the bus never contends.
        last_rd = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            wr_pct = (n < 2000) ? 4 : 1;
            r = int'($urandom_range(0, 99));
            k = ($urandom_range(0, 7) == 0);
            if (r < wr_pct && !last_rd) begin
                w = 1'b1; a = 8'hE0;
            end else if (r < wr_pct + 2 && !last_rd) begin
                w = 1'b1; a = 8'($urandom);
                if (a == 8'hE0) a = 8'hE2;
            end else if (r < wr_pct + 8) begin
                w = 1'b0; a = 8'hE1;
            end else begin
                w = 1'b0; a = 8'($urandom);
                if (a == 8'hE1) a = 8'h00;
            end
            last_rd = !w && (a == 8'hE1);
            cycle(w, a, 8'($urandom), k);
        end
        idle(DEPTH * FRAME + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
